cpu_clk_ctrl: RTL and testbench
===============================

# cpu_clk_ctrl

Generates the CPU's advance strobe and legacy divided clock from the board clock. It sits between the board oscillator and the CPU core and provides three modes: halted, free-running at a programmable divide ratio, and single-step from a debounced push-button. With `div = 0` in run mode, `cpu_clock` toggles every `clk` cycle, giving the fixed clk/2 behaviour the core was originally clocked with. It also keeps a wrapping count of issued steps for the debug display.

## Interface
- `DIV_W`, 21: width of `div` and of the internal divide counter.
- `DEB_CYCLES`, 50000: consecutive stable synchronized samples required to accept a button level change; must be ≥ 1.
- `DEB_W`, 16: width of the debounce counter; must satisfy 2^DEB_W > DEB_CYCLES.

Ports:
- `clk`  in  1  board clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  mode select: 00 halt, 01 run, 10 step, 11 reserved (decoded as halt).
- `div`  in  DIV_W  run-mode period minus one, in `clk` cycles.
- `step_btn`  in  1  raw asynchronous push-button, active high.
- `cpu_clk_en`  out  1  registered one-cycle strobe; the CPU advances when it is high.
- `cpu_clock`  out  1  registered; toggles on every cycle in which `cpu_clk_en` is high.
- `running`  out  1  high while the FSM is in RUN.
- `step_cnt`  out  16  number of strobes issued; wraps from 0xFFFF to 0.

## Operation
- **FSM states:** HALT, RUN, STEP.
  - Every cycle, `state <= decode(mode)`. Mode changes are therefore visible one cycle after they are sampled.
  - All transitions between states are legal.
- **RUN, divide counter `dcnt`:**
  - `dcnt` is forced to 0 in every non-RUN state.
  - In RUN, if `dcnt >= div`: `dcnt <= 0` and `cpu_clk_en <= 1`.
  - Otherwise: `dcnt <= dcnt + 1` and `cpu_clk_en <= 0`.
  - Because the comparison is `>=`, lowering `div` below the current `dcnt` produces a strobe at the next edge. It never wraps through 2^DIV_W.
- **Button synchronizer:** two flops, `s1` then `s2`, both reset to 0.
- **Debouncer:**
  - Holds the accepted level `deb` and counter `bcnt`.
  - If `s2 == deb`: `bcnt <= 0`.
  - Else if `bcnt == DEB_CYCLES-1`: `deb <= s2` and `bcnt <= 0`.
  - Else: `bcnt <= bcnt + 1`.
  - Glitches shorter than DEB_CYCLES cycles are rejected.
- **Edge detect:** `deb_d` is `deb` delayed by one cycle. A press is `deb & ~deb_d`.
- **STEP:**
  - `cpu_clk_en <= press`, giving exactly one strobe per accepted press.
  - A press that occurs in HALT or RUN is discarded, not buffered.
  - Release edges never strobe.
- **HALT:** `cpu_clk_en <= 0`.
- **`cpu_clock`:** `cpu_clock <= cpu_clock ^ cpu_clk_en`, evaluated on the registered strobe.
- **`step_cnt`:** increments by 1 in the cycle after each strobe, in any state; wraps modulo 2^16.
- **`running`:** equals `(state == RUN)`.

## Timing
- **Reset values:** after `rst`, the following are all 0:
  - outputs `cpu_clk_en`, `cpu_clock`, `running`, `step_cnt`;
  - internal `state` = HALT, `dcnt`, `bcnt`, `s1`, `s2`, `deb`, `deb_d`.
  - `rst` has priority over every other input.
  - Reset in the middle of a debounce or divide count aborts it; no strobe is emitted for the partial count.
- **Button held through reset:** seen as a fresh press once reset is released. It strobes if the block is in STEP when `deb` rises.
- **RUN latency:** let E be the first cycle with `state == RUN` (`dcnt == 0`).
  - The first strobe is high in cycle E+1+div.
  - Subsequent strobes are spaced div+1 cycles apart.
  - `div = 0` gives a strobe every cycle, so `cpu_clock` = clk/2.
- **RUN to HALT/STEP:** a strobe registered on the transition edge still appears for that one cycle. After that no RUN strobes occur, and `dcnt` is 0.
- **Step latency:** if `step_btn` is high and clean from the edge that first samples it into `s1` (edge k):
  - `s2` is high after edge k+1.
  - `deb` rises at edge k+1+DEB_CYCLES.
  - `cpu_clk_en` is high for the single cycle following edge k+2+DEB_CYCLES.
- **Mode leaving STEP during a debounce:** if the press edge arrives when `state != STEP`, it is lost.
- **Strobe shape:** `cpu_clk_en` is never high for two consecutive cycles, except in RUN with `div = 0`.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `mode = 01` and `step_btn = 1` → all outputs are 0 during reset and `state` is HALT. After release, `running` = 1 one cycle later.
- **RUN, div = 3:** `mode = 01`, `div = 3` for 40 cycles → strobes exactly every 4 cycles, the first at E+4. `cpu_clock` toggles at each strobe and `step_cnt` = 10.
- **RUN, div = 0:** → `cpu_clk_en` is constantly high from E+1 and `cpu_clock` alternates every cycle. Then change `div` to 5 while `dcnt` = 0 → the next strobe comes 6 cycles later.
- **STEP, single press:** `DEB_CYCLES = 4`, `mode = 10`. Press for 20 cycles → exactly one strobe, at edge k+6, and `step_cnt` += 1. A 3-cycle bounce pulse → no strobe.
- **Mode gating:** a clean press with `mode = 00` → no strobe. Switch to `mode = 10` with the button still held → no strobe until it is released and pressed again.
- **Wrap:** issue 65536 strobes in RUN with `div = 0` → `step_cnt` returns to 0 and `cpu_clock` ends equal to its start value.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: CPU advance strobe and legacy divided clock generator.
// Three modes: halt, free-run at a programmable divide ratio, and single-step
// from a debounced push-button. Also counts issued strobes for the debug display.
module cpu_clk_ctrl #(
  parameter int DIV_W      = 21,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             step_btn,
  output logic             cpu_clk_en,
  output logic             cpu_clock,
  output logic             running,
  output logic [15:0]      step_cnt
);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  // Last debounce count value before the new level is accepted.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  localparam int SYNC_STAGES = 2;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   dcnt_reg, dcnt_next;
  logic               en_reg, en_next;
  logic               cpu_clock_reg;
  logic [15:0]        step_cnt_reg;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic               s2;
  logic               deb_reg, deb_next;
  logic [DEB_W-1:0]   bcnt_reg, bcnt_next;
  logic               deb_d_reg;
  logic               press;

  // ---------------------------------------------------------------------------
  // Button synchronizer: stage 0 samples the raw pin, later stages shift it on.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage captures the asynchronous button.
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= step_btn;
        end
      end else begin : g_next
        // Later stages resolve metastability of the previous stage.
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign s2 = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debouncer: accept a new level only after DEB_CYCLES consecutive samples.
  // ---------------------------------------------------------------------------
  // Next accepted level and stability counter.
  always_comb begin
    deb_next  = deb_reg;
    bcnt_next = bcnt_reg;
    if (s2 == deb_reg) begin
      bcnt_next = '0;
    end else if (bcnt_reg == DEB_LAST) begin
      deb_next  = s2;
      bcnt_next = '0;
    end else begin
      bcnt_next = bcnt_reg + 1'b1;
    end
  end

  // Debouncer state and the one-cycle delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_reg   <= 1'b0;
      bcnt_reg  <= '0;
      deb_d_reg <= 1'b0;
    end else begin
      deb_reg   <= deb_next;
      bcnt_reg  <= bcnt_next;
      deb_d_reg <= deb_reg;
    end
  end

  // Rising edge of the accepted level only; releases never produce a press.
  assign press = deb_reg & ~deb_d_reg;

  // ---------------------------------------------------------------------------
  // Mode FSM with divide counter and strobe generation.
  // ---------------------------------------------------------------------------
  // State, divide counter and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HALT;
      dcnt_reg  <= '0;
      en_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
      en_reg    <= en_next;
    end
  end

  // Mode decode plus per-state strobe and divide-counter behaviour.
  always_comb begin
    state_next = HALT;
    dcnt_next  = '0;
    en_next    = 1'b0;

    // The reserved encoding falls through to HALT.
    case (mode)
      2'b01:   state_next = RUN;
      2'b10:   state_next = STEP;
      default: state_next = HALT;
    endcase

    case (state_reg)
      RUN: begin
        // >= so that lowering div below the running count strobes at once
        // instead of wrapping through the full counter range.
        if (dcnt_reg >= div) begin
          dcnt_next = '0;
          en_next   = 1'b1;
        end else begin
          dcnt_next = dcnt_reg + 1'b1;
          en_next   = 1'b0;
        end
      end
      STEP: begin
        // Presses seen in other states are dropped, never buffered.
        en_next = press;
      end
      default: begin
        en_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Legacy clock and strobe counter, both driven by the registered strobe.
  // ---------------------------------------------------------------------------
  // Toggle the legacy clock and count strobes one cycle after each strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_clock_reg <= 1'b0;
      step_cnt_reg  <= '0;
    end else begin
      cpu_clock_reg <= cpu_clock_reg ^ en_reg;
      step_cnt_reg  <= step_cnt_reg + {15'd0, en_reg};
    end
  end

  assign cpu_clk_en = en_reg;
  assign cpu_clock  = cpu_clock_reg;
  assign running    = (state_reg == RUN);
  assign step_cnt   = step_cnt_reg;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: scoreboard bench for cpu_clk_ctrl. Each scenario pushes the
// cycle numbers at which a strobe is required; a negedge monitor pops them as
// strobes appear and flags missing or unexpected ones.
module tb_cpu_clk_ctrl;

  localparam int DIV_W = 21;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic [DIV_W-1:0] div = '0;
  logic             step_btn = 1'b0;
  logic             cpu_clk_en;
  logic             cpu_clock;
  logic             running;
  logic [15:0]      step_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int exp_q[$];

  cpu_clk_ctrl #(
    .DIV_W(DIV_W),
    .DEB_CYCLES(4),
    .DEB_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .div(div),
    .step_btn(step_btn),
    .cpu_clk_en(cpu_clk_en),
    .cpu_clock(cpu_clock),
    .running(running),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge n (plus #1) cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe scoreboard monitor.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        tests++;
        fails++;
        $display("FAIL strobe_missed: cpu_clk_en=0 at cycle %0d, required 1", exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (cpu_clk_en === 1'b1) begin
        tests++;
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
          void'(exp_q.pop_front());
        end else begin
          fails++;
          $display("FAIL strobe_unexpected: cpu_clk_en=1 at cycle %0d, required 0", cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b01; div = DIV_W'(1000); step_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (cpu_clk_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %b, required 0", cpu_clk_en); end
      tests++;
      if (cpu_clock !== 1'b0) begin fails++; $display("FAIL reset_clock: got %b, required 0", cpu_clock); end
      tests++;
      if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b, required 0", running); end
      tests++;
      if (step_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d, required 0", step_cnt); end
    end
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (running !== 1'b1) begin fails++; $display("FAIL reset_release_running: got %b, required 1", running); end
    mode = 2'b00;
    step_btn = 1'b0;
    tick(14);
    $display("[TB] test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_run_div3();
    logic [15:0] s_cnt;
    logic        s_clk;
    int          c;
    s_cnt = step_cnt; s_clk = cpu_clock; c = cyc;
    mode = 2'b01; div = DIV_W'(3);
    for (int i = 0; i < 10; i++) exp_q.push_back(c + 5 + 4 * i);
    wait_until(c + 5 + 36);
    mode = 2'b00;
    tick(4);
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL div3_pending: %0d strobes outstanding, required 0", exp_q.size()); exp_q.delete(); end
    tests++;
    if (step_cnt !== 16'(s_cnt + 16'd10)) begin fails++; $display("FAIL div3_cnt: got %0d, required %0d", step_cnt, 16'(s_cnt + 16'd10)); end
    tests++;
    if (cpu_clock !== s_clk) begin fails++; $display("FAIL div3_clock: got %b, required %b", cpu_clock, s_clk); end
    $display("[TB] test_run_div3 done at cycle %0d", cyc);
  endtask

  task automatic test_run_div0();
    logic [15:0] s_cnt;
    logic        s_clk;
    logic        exp_clk;
    int          c;
    int          k;
    s_cnt = step_cnt; s_clk = cpu_clock; c = cyc;
    mode = 2'b01; div = '0;
    for (int i = 0; i < 10; i++) exp_q.push_back(c + 2 + i);
    exp_q.push_back(c + 17);
    for (int n = c + 2; n <= c + 11; n++) begin
      wait_until(n);
      k = (n - c - 2) % 2;
      exp_clk = s_clk ^ k[0];
      tests++;
      if (cpu_clock !== exp_clk) begin fails++; $display("FAIL div0_alternate: cycle %0d got %b, required %b", n, cpu_clock, exp_clk); end
    end
    div = DIV_W'(5);
    wait_until(c + 17);
    mode = 2'b00;
    tick(4);
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL div0_pending: %0d strobes outstanding, required 0", exp_q.size()); exp_q.delete(); end
    tests++;
    if (step_cnt !== 16'(s_cnt + 16'd11)) begin fails++; $display("FAIL div0_cnt: got %0d, required %0d", step_cnt, 16'(s_cnt + 16'd11)); end
    tests++;
    if (cpu_clock !== ~s_clk) begin fails++; $display("FAIL div0_clock: got %b, required %b", cpu_clock, ~s_clk); end
    $display("[TB] test_run_div0 done at cycle %0d", cyc);
  endtask

  task automatic test_back_to_back();
    logic [15:0] s_cnt;
    int          c;
    s_cnt = step_cnt;
    // Lowering div below the running count strobes on the next edge.
    c = cyc;
    mode = 2'b01; div = DIV_W'(10);
    exp_q.push_back(c + 9);
    wait_until(c + 8);
    div = DIV_W'(2);
    wait_until(c + 9);
    mode = 2'b00;
    tick(3);
    // A strobe registered on the RUN->HALT edge still appears once.
    c = cyc;
    mode = 2'b01; div = DIV_W'(2);
    exp_q.push_back(c + 4);
    wait_until(c + 3);
    mode = 2'b00;
    tick(6);
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL b2b_pending: %0d strobes outstanding, required 0", exp_q.size()); exp_q.delete(); end
    tests++;
    if (step_cnt !== 16'(s_cnt + 16'd2)) begin fails++; $display("FAIL b2b_cnt: got %0d, required %0d", step_cnt, 16'(s_cnt + 16'd2)); end
    $display("[TB] test_back_to_back done at cycle %0d", cyc);
  endtask

  task automatic test_step();
    logic [15:0] s_cnt;
    int          j;
    mode = 2'b10;
    tick(3);
    s_cnt = step_cnt; j = cyc;
    step_btn = 1'b1;
    exp_q.push_back(j + 7);
    tick(20);
    step_btn = 1'b0;
    tick(10);
    // 3-cycle bounce is shorter than the debounce window.
    step_btn = 1'b1;
    tick(3);
    step_btn = 1'b0;
    tick(10);
    mode = 2'b00;
    tick(2);
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL step_pending: %0d strobes outstanding, required 0", exp_q.size()); exp_q.delete(); end
    tests++;
    if (step_cnt !== 16'(s_cnt + 16'd1)) begin fails++; $display("FAIL step_cnt: got %0d, required %0d", step_cnt, 16'(s_cnt + 16'd1)); end
    $display("[TB] test_step done at cycle %0d", cyc);
  endtask

  task automatic test_mode_gating();
    logic [15:0] s_cnt;
    int          j;
    s_cnt = step_cnt;
    mode = 2'b00;
    tick(2);
    step_btn = 1'b1;
    tick(15);
    mode = 2'b10;
    tick(10);
    step_btn = 1'b0;
    tick(10);
    tests++;
    if (step_cnt !== s_cnt) begin fails++; $display("FAIL gating_held: got %0d strobes counted, required %0d", step_cnt, s_cnt); end
    j = cyc;
    step_btn = 1'b1;
    exp_q.push_back(j + 7);
    tick(12);
    step_btn = 1'b0;
    tick(10);
    mode = 2'b00;
    tick(2);
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL gating_pending: %0d strobes outstanding, required 0", exp_q.size()); exp_q.delete(); end
    tests++;
    if (step_cnt !== 16'(s_cnt + 16'd1)) begin fails++; $display("FAIL gating_cnt: got %0d, required %0d", step_cnt, 16'(s_cnt + 16'd1)); end
    $display("[TB] test_mode_gating done at cycle %0d", cyc);
  endtask

  task automatic test_wrap();
    int c;
    mode = 2'b00;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    tests++;
    if (step_cnt !== 16'd0) begin fails++; $display("FAIL wrap_start_cnt: got %0d, required 0", step_cnt); end
    tests++;
    if (cpu_clock !== 1'b0) begin fails++; $display("FAIL wrap_start_clock: got %b, required 0", cpu_clock); end
    c = cyc;
    mode = 2'b01; div = '0;
    for (int i = 0; i < 65536; i++) exp_q.push_back(c + 2 + i);
    wait_until(c + 65536);
    mode = 2'b00;
    tick(4);
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL wrap_pending: %0d strobes outstanding, required 0", exp_q.size()); exp_q.delete(); end
    tests++;
    if (step_cnt !== 16'd0) begin fails++; $display("FAIL wrap_cnt: got %0d, required 0", step_cnt); end
    tests++;
    if (cpu_clock !== 1'b0) begin fails++; $display("FAIL wrap_clock: got %b, required 0", cpu_clock); end
    $display("[TB] test_wrap done at cycle %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_run_div3();
    test_run_div0();
    test_back_to_back();
    test_step();
    test_mode_gating();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
